// File: rtl/ff_conv_pkg.sv
// Shared types and reverse-table constants for the flip-flop conversion bank.
// The excite() helper is only referenced when the top is built with EXCITE_EN.
package ff_conv_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_SR = 2'b01,
    MODE_JK = 2'b10,
    MODE_T  = 2'b11
  } ff_mode_e;

  // Excitation codes are packed as {a, b}; SR and JK share the same codes.
  localparam logic [1:0] EXC_HOLD = 2'b00;
  localparam logic [1:0] EXC_CLR  = 2'b01;
  localparam logic [1:0] EXC_SET  = 2'b10;

  function automatic logic [1:0] excite(input ff_mode_e m, input logic q, input logic tgt);
    logic [1:0] e;
    e = EXC_HOLD;
    case (m)
      MODE_D:  e = {tgt, 1'b0};
      MODE_T:  e = {q ^ tgt, 1'b0};
      default: e = (q == tgt) ? EXC_HOLD : (tgt ? EXC_SET : EXC_CLR);
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ff_conv_cell.sv
// One emulated flip-flop: next-state mux, D register, sticky SR-illegal flag
// and a combinational change strobe used by the bank's event counter.
module ff_conv_cell
  import ff_conv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  ff_mode_e mode,
  input  logic     hold,
  input  logic     a,
  input  logic     b,
  output logic     q,
  output logic     illegal,
  output logic     chg
);

  logic q_next;
  logic sr_both;

  // In SR and JK modes a lone active input forces q to the value of a.
  always_comb begin
    q_next = q;
    if (!hold) begin
      case (mode)
        MODE_D:  q_next = a;
        MODE_SR: if (a != b) q_next = a;
        MODE_JK: q_next = (a && b) ? ~q : ((a != b) ? a : q);
        MODE_T:  if (a) q_next = ~q;
        default: q_next = q;
      endcase
    end
  end

  assign sr_both = !hold && (mode == MODE_SR) && a && b;
  assign chg     = q_next ^ q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= 1'b0;
      illegal <= 1'b0;
    end else begin
      q <= q_next;
      if (sr_both) illegal <= 1'b1;
    end
  end

endmodule

// File: rtl/ff_conv_bank.sv
// WIDTH-bit bank of D-register flip-flop emulators with a run-time mode and a
// saturating change counter. Define EXCITE_EN to add the tgt/ex_a/ex_b excitation ports.
module ff_conv_bank
  import ff_conv_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_ld,
  input  logic [1:0]       mode_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef EXCITE_EN
  input  logic [WIDTH-1:0] tgt,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
`endif
  output logic [WIDTH-1:0] q,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] illegal,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam int POP_W = $clog2(WIDTH + 1);
  localparam int SUM_W = CNT_W + POP_W;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  ff_mode_e         mode_r;
  logic [WIDTH-1:0] chg;
  logic [POP_W-1:0] pop;
  logic [SUM_W-1:0] sum;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_conv_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .mode    (mode_r),
      .hold    (mode_ld),
      .a       (a[i]),
      .b       (b[i]),
      .q       (q[i]),
      .illegal (illegal[i]),
      .chg     (chg[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) mode_r <= MODE_D;
    else if (mode_ld) mode_r <= ff_mode_e'(mode_in);
  end

  assign mode = mode_r;

  // The sum is widened so the saturation compare never sees a wrapped value.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + POP_W'(chg[i]);
    sum = SUM_W'(chg_cnt) + SUM_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) chg_cnt <= '0;
    else chg_cnt <= (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

`ifdef EXCITE_EN
  always_comb begin
    ex_a = '0;
    ex_b = '0;
    for (int i = 0; i < WIDTH; i++) {ex_a[i], ex_b[i]} = excite(mode_r, q[i], tgt[i]);
  end
`endif

endmodule

// File: tb/tb_ff_conv_bank.sv
// Self-checking bench for ff_conv_bank: directed scenarios plus randomized traffic
// against a table-driven reference model; a second instance uses CNT_W=3.
module tb_ff_conv_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_ld = 1'b0;
  logic [1:0] mode_in = 2'b00;
  logic [3:0] a = 4'b0000;
  logic [3:0] b = 4'b0000;
  logic [3:0] q, illegal, q3, illegal3;
  logic [1:0] mode, mode3;
  logic [7:0] chg_cnt;
  logic [2:0] cnt3;
`ifdef EXCITE_EN
  logic [3:0] tgt = 4'b0000;
  logic [3:0] ex_a, ex_b, ex_a3, ex_b3;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  logic [3:0] m_q;
  logic [1:0] m_mode;
  logic [3:0] m_ill;
  int         m_cnt;
  int         m_cnt3;

  always #5 clk = ~clk;

  ff_conv_bank #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .mode_ld(mode_ld), .mode_in(mode_in), .a(a), .b(b),
`ifdef EXCITE_EN
    .tgt(tgt), .ex_a(ex_a), .ex_b(ex_b),
`endif
    .q(q), .mode(mode), .illegal(illegal), .chg_cnt(chg_cnt)
  );

  ff_conv_bank #(.WIDTH(4), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .mode_ld(mode_ld), .mode_in(mode_in), .a(a), .b(b),
`ifdef EXCITE_EN
    .tgt(tgt), .ex_a(ex_a3), .ex_b(ex_b3),
`endif
    .q(q3), .mode(mode3), .illegal(illegal3), .chg_cnt(cnt3)
  );

  // Next value of one bit given its mode and {a,b}, straight from the characteristic tables.
  function automatic logic model_bit(input logic [1:0] md, input logic qb, input logic x, input logic y);
    logic [1:0] ab;
    ab = {x, y};
    case (md)
      2'b00:   return x;
      2'b01:   return (ab == 2'b10) ? 1'b1 : (ab == 2'b01) ? 1'b0 : qb;
      2'b10:   return (ab == 2'b10) ? 1'b1 : (ab == 2'b01) ? 1'b0 : (ab == 2'b11) ? !qb : qb;
      default: return x ? !qb : qb;
    endcase
  endfunction

  task automatic step(input logic r, input logic ld, input logic [1:0] mi,
                      input logic [3:0] aa, input logic [3:0] bb);
    logic [3:0] nq;
    @(negedge clk);
    rst = r; mode_ld = ld; mode_in = mi; a = aa; b = bb;
    @(posedge clk);
    if (r) begin
      m_q = '0; m_mode = 2'b00; m_ill = '0; m_cnt = 0; m_cnt3 = 0;
    end else if (ld) begin
      m_mode = mi;
    end else begin
      for (int i = 0; i < 4; i++) begin
        nq[i] = model_bit(m_mode, m_q[i], aa[i], bb[i]);
        if (m_mode == 2'b01 && aa[i] && bb[i]) m_ill[i] = 1'b1;
      end
      m_cnt  = m_cnt + $countones(nq ^ m_q);
      m_cnt3 = m_cnt3 + $countones(nq ^ m_q);
      if (m_cnt > 255) m_cnt = 255;
      if (m_cnt3 > 7) m_cnt3 = 7;
      m_q = nq;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 2'b00, 4'b1111, 4'b1111);
    n_total++;
    if ({q, mode, illegal, chg_cnt, cnt3} !== 21'h0) begin
      $display("[TB] FAIL reset: got q=%b mode=%b ill=%b cnt=%0d cnt3=%0d, want all zero",
               q, mode, illegal, chg_cnt, cnt3);
    end else n_pass++;
  endtask

  task automatic test_d_mode();
    step(1'b0, 1'b0, 2'b00, 4'b1010, 4'b0000);
    n_total++;
    if ({q, chg_cnt} !== {4'b1010, 8'd2}) begin
      $display("[TB] FAIL d_mode: got q=%b cnt=%0d, want q=1010 cnt=2", q, chg_cnt);
    end else n_pass++;
  endtask

  task automatic test_sr_mode();
    step(1'b0, 1'b1, 2'b01, 4'b1111, 4'b0000);
    n_total++;
    if ({q, mode, illegal} !== {4'b1010, 2'b01, 4'b0000}) begin
      $display("[TB] FAIL sr_load: got q=%b mode=%b ill=%b, want 1010 01 0000", q, mode, illegal);
    end else n_pass++;
    step(1'b0, 1'b0, 2'b00, 4'b0001, 4'b0001);
    n_total++;
    if ({q, illegal} !== {4'b1010, 4'b0001}) begin
      $display("[TB] FAIL sr_both: got q=%b ill=%b, want 1010 0001", q, illegal);
    end else n_pass++;
    step(1'b0, 1'b0, 2'b00, 4'b0100, 4'b0000);
    n_total++;
    if ({q, illegal, chg_cnt} !== {4'b1110, 4'b0001, 8'd3}) begin
      $display("[TB] FAIL sr_set: got q=%b ill=%b cnt=%0d, want 1110 0001 3", q, illegal, chg_cnt);
    end else n_pass++;
  endtask

  task automatic test_jk_mode();
    step(1'b0, 1'b1, 2'b10, 4'b0000, 4'b0000);
    step(1'b0, 1'b0, 2'b00, 4'b1111, 4'b1111);
    n_total++;
    if ({q, chg_cnt} !== {4'b0001, 8'd7}) begin
      $display("[TB] FAIL jk_toggle1: got q=%b cnt=%0d, want 0001 7", q, chg_cnt);
    end else n_pass++;
    step(1'b0, 1'b0, 2'b00, 4'b1111, 4'b1111);
    n_total++;
    if ({q, chg_cnt} !== {4'b1110, 8'd11}) begin
      $display("[TB] FAIL jk_toggle2: got q=%b cnt=%0d, want 1110 11", q, chg_cnt);
    end else n_pass++;
  endtask

  task automatic test_t_mode();
    logic [3:0] exp_q [3] = '{4'b0001, 4'b0000, 4'b0001};
    step(1'b0, 1'b1, 2'b00, 4'b1111, 4'b0000);
    step(1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
    step(1'b0, 1'b1, 2'b11, 4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'b00, 4'b0001, 4'b0000);
      n_total++;
      if ({q, mode} !== {exp_q[i], 2'b11}) begin
        $display("[TB] FAIL t_toggle%0d: got q=%b mode=%b, want %b 11", i, q, mode, exp_q[i]);
      end else n_pass++;
    end
    step(1'b1, 1'b0, 2'b00, 4'b0001, 4'b0000);
    n_total++;
    if ({q, mode, illegal, chg_cnt, cnt3} !== 21'h0) begin
      $display("[TB] FAIL t_reset: got q=%b mode=%b ill=%b cnt=%0d cnt3=%0d, want all zero",
               q, mode, illegal, chg_cnt, cnt3);
    end else n_pass++;
  endtask

  task automatic test_saturate();
    logic [2:0] exp3 [4] = '{3'd4, 3'd7, 3'd7, 3'd7};
    step(1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000);
    for (int i = 0; i < 70; i++) begin
      step(1'b0, 1'b0, 2'b00, (i % 2 == 0) ? 4'b1111 : 4'b0000, 4'b0000);
      if (i < 4) begin
        n_total++;
        if (cnt3 !== exp3[i]) begin
          $display("[TB] FAIL sat3_%0d: got cnt3=%0d, want %0d", i, cnt3, exp3[i]);
        end else n_pass++;
      end
      if (i == 62 || i == 63 || i == 69) begin
        n_total++;
        if (chg_cnt !== ((i == 62) ? 8'd252 : 8'd255)) begin
          $display("[TB] FAIL sat8_%0d: got cnt=%0d, want %0d", i, chg_cnt, (i == 62) ? 252 : 255);
        end else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [20:0] exp_v;
    step(1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000);
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(5) == 0), 2'($urandom_range(3)),
           4'($urandom_range(15)), 4'($urandom_range(15)));
      exp_v = {m_q, m_mode, m_ill, 8'(m_cnt), 3'(m_cnt3)};
      n_total++;
      if ({q, mode, illegal, chg_cnt, cnt3} !== exp_v) begin
        $display("[TB] FAIL random_%0d: got q=%b mode=%b ill=%b cnt=%0d cnt3=%0d, want q=%b mode=%b ill=%b cnt=%0d cnt3=%0d",
                 i, q, mode, illegal, chg_cnt, cnt3, m_q, m_mode, m_ill, m_cnt, m_cnt3);
      end else n_pass++;
    end
  endtask

`ifdef EXCITE_EN
  task automatic test_excite();
    step(1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000);
    step(1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000);
    step(1'b0, 1'b0, 2'b00, 4'b0011, 4'b1100);
    tgt = 4'b0101;
    #1;
    n_total++;
    if ({q, ex_a, ex_b} !== {4'b0011, 4'b0100, 4'b0010}) begin
      $display("[TB] FAIL excite_sr: got q=%b ex_a=%b ex_b=%b, want 0011 0100 0010", q, ex_a, ex_b);
    end else n_pass++;
    step(1'b0, 1'b0, 2'b00, ex_a, ex_b);
    n_total++;
    if (q !== 4'b0101) begin
      $display("[TB] FAIL excite_apply: got q=%b, want 0101", q);
    end else n_pass++;
  endtask
`endif

  initial begin
    m_q = '0; m_mode = 2'b00; m_ill = '0; m_cnt = 0; m_cnt3 = 0;
    test_reset();
    test_d_mode();
    test_sr_mode();
    test_jk_mode();
    test_t_mode();
    test_saturate();
    test_random();
`ifdef EXCITE_EN
    test_excite();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
